// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//    Tracks in-flight branch predictions in a small circular FIFO.
//    Each branch resolving in EX pops the oldest prediction and compares it
//    with the actual outcome. A mismatch flushes the younger pipeline
//    stages, redirects fetch to the correct path and empties the FIFO,
//    because every queued entry is younger and therefore on the wrong path.
//    Every resolution, including a pop from an empty queue, produces a
//    one-cycle training pulse for the predictor.
//
// Ports:
//    clk              in   rising-edge clock
//    reset            in   synchronous active-high reset
//    pred_valid       in   push a prediction this cycle
//    pred_taken       in   predicted direction of the pushed branch
//    branchex         in   oldest in-flight branch resolves this cycle (pop)
//    outcome          in   actual direction, qualified by branchex
//    ex_target        in   taken-path address of the resolving branch
//    ex_pc_plus4      in   fall-through address of the resolving branch
//    flush            out  one-cycle squash pulse
//    redirect_pc      out  corrected fetch address, held between flushes
//    update_valid     out  one-cycle predictor training pulse
//    update_taken     out  outcome to train with
//    branch_count     out  resolved branches (wraps at 2^32)
//    mispredict_count out  mispredicted branches (wraps at 2^32)
//    underflow_err    out  sticky: pop seen with an empty queue
//    overflow_err     out  sticky: push dropped because queue was full
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int ADDR_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pred_valid,
   input  logic              pred_taken,
   input  logic              branchex,
   input  logic              outcome,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic [ADDR_W-1:0] ex_pc_plus4,
   output logic              flush,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              update_valid,
   output logic              update_taken,
   output logic [31:0]       branch_count,
   output logic [31:0]       mispredict_count,
   output logic              underflow_err,
   output logic              overflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Queue state
   logic [DEPTH-1:0]  mem_q,    mem_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   // Output registers
   logic              flush_q,        flush_d;
   logic [ADDR_W-1:0] redirect_q,     redirect_d;
   logic              upd_valid_q,    upd_valid_d;
   logic              upd_taken_q,    upd_taken_d;
   logic [31:0]       br_cnt_q,       br_cnt_d;
   logic [31:0]       mis_cnt_q,      mis_cnt_d;
   logic              underflow_q,    underflow_d;
   logic              overflow_q,     overflow_d;

   // Decoded per-cycle events
   logic empty_s;
   logic full_s;
   logic pop_ok_s;
   logic head_s;
   logic mispredict_s;
   logic push_ok_s;

   // Event decode: which pops are real, which pushes are accepted
   always_comb begin
      empty_s      = (count_q == {CNT_W{1'b0}});
      full_s       = (count_q == FULL_CNT);
      pop_ok_s     = branchex & ~empty_s;
      head_s       = mem_q[rd_ptr_q];
      mispredict_s = pop_ok_s & (head_s != outcome);
      // A pop frees the head slot in the same cycle, so a full queue can
      // still take a push; pushes alongside a mispredict are wrong-path.
      push_ok_s    = pred_valid & ~mispredict_s & (~full_s | pop_ok_s);
   end

   // Next-state computation for the queue, counters and output registers
   always_comb begin
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      flush_d     = 1'b0;
      redirect_d  = redirect_q;
      upd_valid_d = 1'b0;
      upd_taken_d = upd_taken_q;
      br_cnt_d    = br_cnt_q;
      mis_cnt_d   = mis_cnt_q;
      underflow_d = underflow_q;
      overflow_d  = overflow_q;

      // Every pop trains the predictor, even one from an empty queue.
      if (branchex) begin
         upd_valid_d = 1'b1;
         upd_taken_d = outcome;
      end else begin
         upd_taken_d = upd_taken_q;
      end

      if (branchex && empty_s) begin
         underflow_d = 1'b1;
      end else begin
         underflow_d = underflow_q;
      end

      // Only a genuine full-queue drop is an overflow, not a wrong-path discard.
      if (pred_valid && !mispredict_s && !push_ok_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end

      if (pop_ok_s) begin
         br_cnt_d = br_cnt_q + 32'd1;
      end else begin
         br_cnt_d = br_cnt_q;
      end

      if (mispredict_s) begin
         flush_d    = 1'b1;
         redirect_d = outcome ? ex_target : ex_pc_plus4;
         mis_cnt_d  = mis_cnt_q + 32'd1;
         // Empty the queue by collapsing the read pointer onto the write pointer.
         rd_ptr_d   = wr_ptr_q;
         count_d    = {CNT_W{1'b0}};
      end else begin
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_ok_s) begin
            mem_d[wr_ptr_q] = pred_taken;
            wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
         endcase
      end
   end

   // State register with synchronous reset taking priority over push/pop
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q       <= {DEPTH{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         wr_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         flush_q     <= 1'b0;
         redirect_q  <= {ADDR_W{1'b0}};
         upd_valid_q <= 1'b0;
         upd_taken_q <= 1'b0;
         br_cnt_q    <= 32'd0;
         mis_cnt_q   <= 32'd0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         flush_q     <= flush_d;
         redirect_q  <= redirect_d;
         upd_valid_q <= upd_valid_d;
         upd_taken_q <= upd_taken_d;
         br_cnt_q    <= br_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   assign flush            = flush_q;
   assign redirect_pc      = redirect_q;
   assign update_valid     = upd_valid_q;
   assign update_taken     = upd_taken_q;
   assign branch_count     = br_cnt_q;
   assign mispredict_count = mis_cnt_q;
   assign underflow_err    = underflow_q;
   assign overflow_err     = overflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

   localparam int ADDR_W = 64;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset, pred_valid, pred_taken, branchex, outcome;
   logic [ADDR_W-1:0] ex_target, ex_pc_plus4;
   logic              flush, update_valid, update_taken, underflow_err, overflow_err;
   logic [ADDR_W-1:0] redirect_pc;
   logic [31:0]       branch_count, mispredict_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: predictions as a plain queue, outputs as values
   bit                mq[$];
   bit                e_flush, e_upd, e_updt, e_under, e_over;
   logic [ADDR_W-1:0] e_rpc;
   int unsigned       e_bc, e_mc;

   branch_resolve_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .branchex(branchex), .outcome(outcome),
      .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
      .flush(flush), .redirect_pc(redirect_pc),
      .update_valid(update_valid), .update_taken(update_taken),
      .branch_count(branch_count), .mispredict_count(mispredict_count),
      .underflow_err(underflow_err), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Predict the outputs visible after the coming edge from the current inputs
   task automatic model_step();
      bit mis;
      bit head;
      mis = 1'b0;
      if (reset) begin
         mq.delete();
         e_flush = 0; e_upd = 0; e_updt = 0; e_under = 0; e_over = 0;
         e_rpc = '0; e_bc = 0; e_mc = 0;
      end else begin
         e_flush = 0;
         e_upd   = 0;
         if (branchex) begin
            e_upd  = 1;
            e_updt = outcome;
            if (mq.size() == 0) begin
               e_under = 1;
            end else begin
               head = mq.pop_front();
               e_bc++;
               if (head != outcome) begin
                  mis = 1;
                  e_flush = 1;
                  e_mc++;
                  e_rpc = outcome ? ex_target : ex_pc_plus4;
                  mq.delete();
               end
            end
         end
         if (pred_valid && !mis) begin
            if (mq.size() < DEPTH) mq.push_back(pred_taken);
            else e_over = 1;
         end
      end
   endtask

   task automatic model_check();
      chk("flush", flush, e_flush);
      chk("redirect_pc", redirect_pc, e_rpc);
      chk("update_valid", update_valid, e_upd);
      chk("update_taken", update_taken, e_updt);
      chk("branch_count", branch_count, e_bc);
      chk("mispredict_count", mispredict_count, e_mc);
      chk("underflow_err", underflow_err, e_under);
      chk("overflow_err", overflow_err, e_over);
      chk("occupancy", dut.count_q, mq.size());
   endtask

   // One clock: drive inputs, advance model, sample just after the edge
   task automatic cyc(input bit rs, input bit pv, input bit pt, input bit bx,
                      input bit oc, input logic [63:0] tg, input logic [63:0] p4);
      reset = rs; pred_valid = pv; pred_taken = pt;
      branchex = bx; outcome = oc; ex_target = tg; ex_pc_plus4 = p4;
      model_step();
      @(posedge clk);
      #1;
      model_check();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 64'h0, 64'h0);
   endtask

   task automatic push(input bit t);
      cyc(0, 1, t, 0, 0, 64'h0, 64'h0);
   endtask

   task automatic pop(input bit o);
      cyc(0, 0, 0, 1, o, 64'hA000, 64'hB000);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 64'h0, 64'h0);
   endtask

   initial begin
      reset = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0;
      branchex = 1'b0; outcome = 1'b0; ex_target = '0; ex_pc_plus4 = '0;

      // Reset state
      do_reset();
      do_reset();
      chk("rst_flush", flush, 0);
      chk("rst_upd", update_valid, 0);
      chk("rst_bc", branch_count, 0);
      chk("rst_rpc", redirect_pc, 0);

      // Correct prediction, first push right after reset release
      push(1); idle(); pop(1);
      chk("ok_upd", update_valid, 1);
      chk("ok_updt", update_taken, 1);
      chk("ok_flush", flush, 0);
      chk("ok_bc", branch_count, 1);
      chk("ok_mc", mispredict_count, 0);
      idle();
      chk("ok_upd_pulse", update_valid, 0);

      // Mispredict with younger entries, pushed wrong-path branch discarded
      do_reset();
      push(1); push(0); push(1);
      cyc(0, 1, 1, 1, 0, 64'h100, 64'h44);
      chk("mis_flush", flush, 1);
      chk("mis_rpc", redirect_pc, 64'h44);
      chk("mis_mc", mispredict_count, 1);
      chk("mis_occ", dut.count_q, 0);
      idle();
      chk("mis_flush_pulse", flush, 0);
      chk("mis_rpc_hold", redirect_pc, 64'h44);

      // Taken-path redirect
      push(0);
      cyc(0, 0, 0, 1, 1, 64'h100, 64'h44);
      chk("mis_rpc_taken", redirect_pc, 64'h100);

      // Overflow then drain with matching outcomes
      do_reset();
      push(1); push(0); push(1); push(1); push(0);
      chk("ovf_err", overflow_err, 1);
      chk("ovf_occ", dut.count_q, 4);
      pop(1); chk("ovf_p0", update_valid, 1); chk("ovf_f0", flush, 0);
      pop(0); chk("ovf_p1", update_valid, 1); chk("ovf_f1", flush, 0);
      pop(1); chk("ovf_p2", update_valid, 1); chk("ovf_f2", flush, 0);
      pop(1); chk("ovf_p3", update_valid, 1); chk("ovf_f3", flush, 0);
      chk("ovf_bc", branch_count, 4);
      chk("ovf_mc", mispredict_count, 0);

      // Full queue with simultaneous push/pop across pointer wrap
      do_reset();
      for (int i = 0; i < 4; i++) push(0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, i[0], 1, (i < 4) ? 1'b0 : ((i - 4) % 2 == 1), 64'h0, 64'h0);
         chk("full_occ", dut.count_q, 4);
         chk("full_ovf", overflow_err, 0);
         chk("full_flush", flush, 0);
      end
      chk("full_bc", branch_count, 8);
      chk("full_mc", mispredict_count, 0);

      // Pop from empty queue
      do_reset();
      pop(1);
      chk("emp_under", underflow_err, 1);
      chk("emp_flush", flush, 0);
      chk("emp_bc", branch_count, 0);
      chk("emp_upd", update_valid, 1);
      chk("emp_updt", update_taken, 1);

      // Reset coincident with a pop while 3 entries are queued
      do_reset();
      push(0); push(1); push(1);
      cyc(1, 1, 1, 1, 1, 64'h55, 64'h66);
      chk("rmid_flush", flush, 0);
      chk("rmid_upd", update_valid, 0);
      chk("rmid_bc", branch_count, 0);
      chk("rmid_occ", dut.count_q, 0);
      push(1); idle(); pop(1);
      chk("rmid_upd2", update_valid, 1);
      chk("rmid_bc2", branch_count, 1);
      chk("rmid_mc2", mispredict_count, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(99) == 0), ($urandom_range(1) == 1), $urandom_range(1),
             ($urandom_range(9) < 4), $urandom_range(1),
             {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
